// File: rtl/init_initiator.sv
// Host-side link-setup initiator: sends "UTN", checks "UTNv2\n", sends a 16-bit
// sample rate and parses "OK\n" / "ERROR\n" over four-phase UART byte handshakes.
module init_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 12_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] samp_rate_in,
  output logic        tx_rq,
  input  logic        tx_st,
  output logic [7:0]  dato_tx,
  input  logic        rx_rq,
  output logic        rx_st,
  input  logic [7:0]  dato_rx,
  output logic        busy,
  output logic        done,
  output logic [1:0]  result
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] SEND_U  = 4'd1;
  localparam logic [3:0] SEND_T  = 4'd2;
  localparam logic [3:0] SEND_N  = 4'd3;
  localparam logic [3:0] CHK_ID  = 4'd4;
  localparam logic [3:0] SEND_LO = 4'd5;
  localparam logic [3:0] SEND_HI = 4'd6;
  localparam logic [3:0] RESP0   = 4'd7;
  localparam logic [3:0] CHK_OK  = 4'd8;
  localparam logic [3:0] CHK_ERR = 4'd9;
  localparam logic [3:0] FAIL    = 4'd10;
  localparam logic [3:0] FINISH  = 4'd11;

  logic [3:0]      state_q, state_d;
  logic            tx_st_q, rx_rq_q;
  logic [15:0]     samp_q, samp_d;
  logic            tx_rq_q, tx_rq_d, rx_st_q, rx_st_d;
  logic [7:0]      dato_tx_q, dato_tx_d, rx_byte_q, rx_byte_d;
  logic [2:0]      idx_q, idx_d;
  logic [1:0]      result_q, result_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [CntW-1:0] tcnt_q, tcnt_d;
  logic            tx_sent, rx_eval, timeout;
  logic [7:0]      tx_byte;

  function automatic logic [7:0] id_byte(input logic [2:0] i);
    case (i)
      3'd0:    id_byte = 8'h55;
      3'd1:    id_byte = 8'h54;
      3'd2:    id_byte = 8'h4E;
      3'd3:    id_byte = 8'h76;
      3'd4:    id_byte = 8'h32;
      default: id_byte = 8'h0A;
    endcase
  endfunction

  // Tail of "ERROR\n" once the leading 'E' has been seen.
  function automatic logic [7:0] err_byte(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd3: err_byte = 8'h52;
      3'd2:             err_byte = 8'h4F;
      default:          err_byte = 8'h0A;
    endcase
  endfunction

  always_comb begin
    case (state_q)
      SEND_U:  tx_byte = 8'h55;
      SEND_T:  tx_byte = 8'h54;
      SEND_N:  tx_byte = 8'h4E;
      SEND_LO: tx_byte = samp_q[7:0];
      SEND_HI: tx_byte = samp_q[15:8];
      default: tx_byte = 8'h00;
    endcase
  end

  assign timeout = (state_q != IDLE) && (state_q != FINISH) && (state_q != FAIL) &&
                   (tcnt_q == CntW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    tx_rq_d   = tx_rq_q;
    rx_st_d   = rx_st_q;
    dato_tx_d = dato_tx_q;
    rx_byte_d = rx_byte_q;
    idx_d     = idx_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_sent   = 1'b0;
    rx_eval   = 1'b0;
    if (timeout) begin
      state_d = FAIL;
    end else begin
      if (state_q inside {SEND_U, SEND_T, SEND_N, SEND_LO, SEND_HI}) begin
        if (!tx_rq_q && !tx_st_q) begin
          tx_rq_d   = 1'b1;
          dato_tx_d = tx_byte;
        end else if (tx_rq_q && tx_st_q) begin
          tx_rq_d = 1'b0;
          tx_sent = 1'b1;
        end
      end
      if (state_q inside {CHK_ID, RESP0, CHK_OK, CHK_ERR}) begin
        if (rx_rq_q && !rx_st_q) begin
          rx_st_d   = 1'b1;
          rx_byte_d = dato_rx;
        end else if (!rx_rq_q && rx_st_q) begin
          rx_st_d = 1'b0;
          rx_eval = 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          busy_d = 1'b0;
          if (start) begin
            samp_d   = samp_rate_in;
            result_d = 2'd0;
            busy_d   = 1'b1;
            idx_d    = 3'd0;
            state_d  = SEND_U;
          end
        end
        SEND_U:  if (tx_sent) state_d = SEND_T;
        SEND_T:  if (tx_sent) state_d = SEND_N;
        SEND_N:  if (tx_sent) state_d = CHK_ID;
        CHK_ID: begin
          if (rx_eval) begin
            if (rx_byte_q != id_byte(idx_q)) begin
              state_d = FAIL;
            end else if (idx_q == 3'd5) begin
              idx_d   = 3'd0;
              state_d = SEND_LO;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        SEND_LO: if (tx_sent) state_d = SEND_HI;
        SEND_HI: if (tx_sent) state_d = RESP0;
        RESP0: begin
          if (rx_eval) begin
            case (rx_byte_q)
              8'h4F:   state_d = CHK_OK;
              8'h45:   state_d = CHK_ERR;
              default: state_d = FAIL;
            endcase
          end
        end
        CHK_OK: begin
          if (rx_eval) begin
            if (rx_byte_q != ((idx_q == 3'd0) ? 8'h4B : 8'h0A)) begin
              state_d = FAIL;
            end else if (idx_q == 3'd1) begin
              result_d = 2'd1;
              state_d  = FINISH;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        CHK_ERR: begin
          if (rx_eval) begin
            if (rx_byte_q != err_byte(idx_q)) begin
              state_d = FAIL;
            end else if (idx_q == 3'd4) begin
              result_d = 2'd2;
              state_d  = FINISH;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        FAIL: begin
          tx_rq_d  = 1'b0;
          rx_st_d  = 1'b0;
          result_d = 2'd3;
          state_d  = FINISH;
        end
        FINISH: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Any progress (state or handshake phase) restarts the watchdog.
    if (state_q == IDLE || state_q == FINISH || state_d != state_q ||
        tx_rq_d != tx_rq_q || rx_st_d != rx_st_q) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_st_q   <= 1'b0;
      rx_rq_q   <= 1'b0;
      samp_q    <= 16'h0000;
      tx_rq_q   <= 1'b0;
      rx_st_q   <= 1'b0;
      dato_tx_q <= 8'h00;
      rx_byte_q <= 8'h00;
      idx_q     <= 3'd0;
      result_q  <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      tx_st_q   <= tx_st;
      rx_rq_q   <= rx_rq;
      samp_q    <= samp_d;
      tx_rq_q   <= tx_rq_d;
      rx_st_q   <= rx_st_d;
      dato_tx_q <= dato_tx_d;
      rx_byte_q <= rx_byte_d;
      idx_q     <= idx_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign tx_rq   = tx_rq_q;
  assign rx_st   = rx_st_q;
  assign dato_tx = dato_tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;

endmodule

// File: doc/init_initiator.md
# init_initiator

Host-side initiator of the link-setup handshake. On `start` it sends "UTN", checks that the far end answers "UTNv2\n", sends a 16-bit sample rate (low byte first), then parses "OK\n" or "ERROR\n". It sits between a byte-level UART TX/RX pair and the control logic of a board that drives a remote unit (the board-side init_module) or acts as its bench partner.

## Interface
- `TIMEOUT_CYCLES`, default 12_000_000: maximum cycles spent waiting in any single handshake phase before aborting. Must be ≥ 2. Counter width is $clog2(TIMEOUT_CYCLES+1).
- `clk` in 1: single clock domain.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: a level sampled while idle; starts one handshake.
- `samp_rate_in` in 16: sample rate to request; latched on the accepted `start`.
- `tx_rq` out 1: request to the UART TX to send `dato_tx`.
- `tx_st` in 1: TX acknowledge.
- `dato_tx` out 8: byte to transmit; stable while `tx_rq`=1.
- `rx_rq` in 1: UART RX has a byte on `dato_rx`.
- `rx_st` out 1: RX acknowledge.
- `dato_rx` in 8: received byte.
- `busy` out 1: high from the accepted `start` until the cycle `done` pulses, inclusive.
- `done` out 1: one-cycle pulse at the end of a handshake.
- `result` out 2: outcome code. 0 = none, 1 = OK, 2 = far end sent ERROR, 3 = protocol mismatch or timeout. Held until the next accepted `start`.

## Operation
- `tx_st` and `rx_rq` each pass through one register stage. All decisions below use the registered versions.
- **TX four-phase handshake** (per byte):
  - Wait for `tx_st_reg`=0 and `tx_rq`=0.
  - Drive `dato_tx` and set `tx_rq`=1.
  - Wait for `tx_st_reg`=1, then clear `tx_rq`. The byte counts as sent.
- **RX four-phase handshake** (per byte):
  - On `rx_rq_reg`=1 with `rx_st`=0: capture `dato_rx` and set `rx_st`=1.
  - On `rx_rq_reg`=0 with `rx_st`=1: clear `rx_st` and evaluate the captured byte.
- **States:**
  - IDLE: `busy`=0. On `start`=1, latch `samp_rate_in`, set `result`=0, go to SEND_U.
  - SEND_U → SEND_T → SEND_N: send 0x55, 0x54, 0x4E.
  - CHK_ID: receive 6 bytes compared against "UTNv2\n" (0x55 0x54 0x4E 0x76 0x32 0x0A) using a 3-bit index. On the first mismatch go to FAIL immediately; the remaining bytes are not consumed.
  - SEND_LO, SEND_HI: send `samp_rate[7:0]`, then `samp_rate[15:8]`.
  - RESP0: receive one byte.
    - 0x4F ('O') → CHK_OK.
    - 0x45 ('E') → CHK_ERR.
    - Anything else → FAIL.
  - CHK_OK: expect 0x4B, 0x0A. On match go to FINISH with `result`=1; otherwise FAIL.
  - CHK_ERR: expect 0x52 0x52 0x4F 0x52 0x0A. On match go to FINISH with `result`=2; otherwise FAIL.
  - FAIL: force `tx_rq`=0 and `rx_st`=0, set `result`=3, go to FINISH.
  - FINISH: pulse `done` for one cycle, return to IDLE.
- **Timeout:** a counter clears on every state change and every handshake phase change, and increments otherwise in all states except IDLE and FINISH. When it reaches `TIMEOUT_CYCLES`, go to FAIL.
- `start` is ignored while `busy`=1.
- RX bytes arriving while IDLE are not acknowledged: `rx_st` stays 0.

## Timing
- Reset values: `tx_rq`=0, `rx_st`=0, `dato_tx`=0x00, `busy`=0, `done`=0, `result`=0, state IDLE, timeout counter 0.
- `rst` asserted mid-handshake:
  - Next edge: all outputs return to their reset values, even with `tx_st`/`rx_rq` still high.
  - After reset, a byte left pending on RX is acknowledged only after the next `start`.
- `busy` rises the cycle after `start` is sampled. `tx_rq` for 'U' rises one cycle later.
- TX side:
  - `tx_rq` falls 2 cycles after `tx_st` rises (one for the sync register, one to react).
  - The next `tx_rq` rises no earlier than 2 cycles after `tx_st` falls.
- RX side:
  - `rx_st` rises 2 cycles after `rx_rq` rises and falls 2 cycles after `rx_rq` falls.
  - Byte evaluation happens on the edge where `rx_st` falls.
- `done` asserts exactly 1 cycle after entering FINISH. `busy` falls on the following cycle.
- A timeout abort lands in FAIL on the edge where the counter equals `TIMEOUT_CYCLES`.
- `dato_tx` changes only on edges where `tx_rq` rises.

## Test plan
- **Happy path.** `samp_rate_in`=8000 (0x1F40) with a responder model that replies correctly.
  - Required TX bytes: 0x55 0x54 0x4E 0x40 0x1F.
  - Feed "UTNv2\n", then "OK\n".
  - Required: `done` pulse, `result`=1, `busy`=0 afterward.
- **Far-end error.** `samp_rate_in`=12345; responder replies "UTNv2\n" then "ERROR\n". Required: `result`=2, exactly 5 TX bytes sent.
- **Bad ID.** ID reply "UTNx…", with 0x78 at index 3. Required: FAIL right after the 4th RX byte, `result`=3, no samp-rate bytes sent, `rx_st`=0.
- **Timeout.** `TIMEOUT_CYCLES`=100 and `tx_st` held at 0. Required: `tx_rq` high for 'U', then dropped; `done` pulses with `result`=3 within 100+3 cycles of `tx_rq` rising.
- **Reset mid-byte.** Assert `rst` while `tx_rq`=1 and `tx_st`=1. Required: next cycle `tx_rq`=0, `busy`=0, `result`=0. A new `start` then completes the happy path normally.
- **Start while busy.** Pulse `start` again during CHK_ID with a different `samp_rate_in`. Required: ignored; the transmitted rate bytes equal the first latched value.
